biriscv_fetch_unit: RTL

- Front-end fetch stage feeding the decode stage's fetch FIFO.
- Owns the fetch PC and issues 64-bit aligned reads to the instruction cache.
- Applies branch-predictor redirects, discards stale responses after a branch, and presents {instr, pc, pred_branch, fault} with a valid/accept handshake.
- A one-entry skid buffer absorbs decode back-pressure.

---
 rtl/biriscv_fetch_pkg.sv | 22 ++
 rtl/biriscv_fetch_skid.sv | 49 ++++
 rtl/biriscv_fetch_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/biriscv_fetch_pkg.sv
// Shared types for the biRISC-V fetch front end.
// State encoding, bundle layout and filler instruction.
package biriscv_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  localparam int          BUNDLE_W    = 64 + 32 + 2 + 2;

  typedef struct packed {
    logic [63:0] instr;
    logic [31:0] pc;
    logic [1:0]  pred;
    logic        fault_fetch;
    logic        fault_page;
  } fetch_bundle_t;

endpackage

// File: rtl/biriscv_fetch_skid.sv
// One-entry skid buffer with valid/accept and flush.
// Passes input through when empty, holds a stalled beat otherwise.
module biriscv_fetch_skid
  import biriscv_fetch_pkg::*;
#(
  parameter int W = BUNDLE_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         out_accept_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         full_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (full_q) begin
      if (out_accept_i) full_d = 1'b0;
    end else if (in_valid_i && !out_accept_i) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid_o = full_q | in_valid_i;
  assign out_data_o  = full_q ? data_q : in_data_i;
  assign full_o      = full_q;

endmodule

// File: rtl/biriscv_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues 64-bit icache reads
// and hands {instr, pc, pred, fault} bundles to decode.
module biriscv_fetch_unit
  import biriscv_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_PC   = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_branch_o,
  output logic        fetch_fault_fetch_o,
  output logic        fetch_fault_page_o,
  input  logic        fetch_accept_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,
  output logic [31:0] pc_f_o,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_req_q, pc_req_d;
  logic [1:0]   pred_q, pred_d;
  logic         stop_q, stop_d;

  logic          resp_valid;
  logic          resp_fault;
  logic          launch;
  logic [1:0]    pred_mask;
  logic [31:0]   seq_pc;
  logic [31:0]   npc;
  fetch_bundle_t resp_b;
  fetch_bundle_t out_b;
  logic          skid_valid;
  logic          skid_full;
  logic [BUNDLE_W-1:0] skid_data;

  always_comb begin
    resp_valid = (state_q == ST_WAIT) & icache_valid_i
               & ~branch_request_i;
    resp_fault = icache_error_i | icache_page_fault_i;

    // back-to-back issue only when the current bundle leaves now
    icache_rd_o = rst_ni & ~skid_full & ~stop_q
                & ((state_q == ST_FETCH)
                 | (resp_valid & ~resp_fault & fetch_accept_i));
    launch = icache_rd_o & icache_accept_i;

    pred_mask = {next_taken_f_i[1], next_taken_f_i[0] & ~pc_q[2]};
    seq_pc    = {pc_q[31:3] + 29'd1, 3'b000};
    npc       = (|pred_mask) ? next_pc_f_i : seq_pc;

    resp_b.instr = resp_fault ? 64'd0
                 : {icache_inst_i[63:32],
                    pc_req_q[2] ? NOP_INSTR : icache_inst_i[31:0]};
    resp_b.pc          = pc_req_q;
    resp_b.pred        = pred_q;
    resp_b.fault_fetch = icache_error_i;
    resp_b.fault_page  = icache_page_fault_i;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_req_d = pc_req_q;
    pred_d   = pred_q;
    stop_d   = stop_q;

    unique case (state_q)
      ST_FETCH: if (launch) state_d = ST_WAIT;
      ST_WAIT:  if (icache_valid_i) state_d = ST_FETCH;
      ST_DRAIN: if (icache_valid_i) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase

    if (launch) begin
      state_d  = ST_WAIT;
      pc_d     = npc;
      pc_req_d = pc_q;
      pred_d   = pred_mask;
    end

    if (resp_valid && resp_fault) stop_d = 1'b1;

    if (branch_request_i) begin
      pc_d   = branch_pc_i;
      stop_d = 1'b0;
      unique case (state_q)
        ST_FETCH: state_d = launch ? ST_DRAIN : ST_FETCH;
        ST_WAIT:  state_d = icache_valid_i ? ST_FETCH : ST_DRAIN;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_FETCH;
      pc_q     <= BOOT_PC;
      pc_req_q <= '0;
      pred_q   <= '0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_req_q <= pc_req_d;
      pred_q   <= pred_d;
      stop_q   <= stop_d;
    end
  end

  biriscv_fetch_skid #(
    .W(BUNDLE_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (branch_request_i),
    .in_valid_i  (resp_valid),
    .in_data_i   (resp_b),
    .out_accept_i(fetch_accept_i),
    .out_valid_o (skid_valid),
    .out_data_o  (skid_data),
    .full_o      (skid_full)
  );

  always_comb begin
    out_b = fetch_bundle_t'(skid_data);
    fetch_valid_o = skid_valid & ~branch_request_i & rst_ni;
    fetch_instr_o       = fetch_valid_o ? out_b.instr : 64'd0;
    fetch_pc_o          = fetch_valid_o ? out_b.pc : 32'd0;
    fetch_pred_branch_o = fetch_valid_o ? out_b.pred : 2'd0;
    fetch_fault_fetch_o = fetch_valid_o & out_b.fault_fetch;
    fetch_fault_page_o  = fetch_valid_o & out_b.fault_page;
  end

  assign icache_pc_o = {pc_q[31:3], 3'b000};
  assign pc_f_o      = pc_q;

endmodule
